// File: rtl/uart_rx_byte.sv
// UART receiver: 2-FF synchronised rx, start/data/odd-parity/stop framing,
// mid-bit sampling, valid/ready output with frame, parity and overrun pulses.
module uart_rx_byte #(
    parameter int BR         = 434,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  data_rdy,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_vld,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge on rx_s
    // S_START  | start bit; mid-bit high sample means glitch, back to idle
    // S_DATA   | DATA_WIDTH data bits, LSB first
    // S_PARITY | odd parity bit
    // S_STOP   | stop bit; frame is judged at its midpoint

    localparam int CW = $clog2(BR);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BR_HALF  = CW'(BR / 2);
    localparam logic [CW-1:0] BR_LAST  = CW'(BR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s, rx_s_d;
    logic [CW-1:0]           br_cnt, br_cnt_nxt;
    logic [BW-1:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
    logic                    p_bit, p_bit_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    data_vld_nxt;
    logic                    parity_err_nxt, frame_err_nxt, overrun_err_nxt;
    logic                    fall, sample, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall   = rx_s_d & ~rx_s;
    assign sample = (br_cnt == BR_HALF);
    assign last   = (br_cnt == BR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            br_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            p_bit       <= 1'b0;
            data        <= '0;
            data_vld    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            br_cnt      <= br_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shreg       <= shreg_nxt;
            p_bit       <= p_bit_nxt;
            data        <= data_nxt;
            data_vld    <= data_vld_nxt;
            parity_err  <= parity_err_nxt;
            frame_err   <= frame_err_nxt;
            overrun_err <= overrun_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        br_cnt_nxt      = last ? '0 : br_cnt + 1'b1;
        bit_cnt_nxt     = bit_cnt;
        shreg_nxt       = shreg;
        p_bit_nxt       = p_bit;
        data_nxt        = data;
        data_vld_nxt    = data_vld & ~data_rdy;
        parity_err_nxt  = 1'b0;
        frame_err_nxt   = 1'b0;
        overrun_err_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                br_cnt_nxt = '0;
                if (fall) state_nxt = S_START;
            end
            S_START: begin
                if (sample && rx_s) begin
                    state_nxt  = S_IDLE;
                    br_cnt_nxt = '0;
                end else if (last) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                if (sample) shreg_nxt[bit_cnt] = rx_s;
                if (last) begin
                    if (bit_cnt == BIT_LAST) state_nxt = S_PARITY;
                    else bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (sample) p_bit_nxt = rx_s;
                if (last) state_nxt = S_STOP;
            end
            S_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (sample) begin
                    state_nxt  = S_IDLE;
                    br_cnt_nxt = '0;
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                    end else if (p_bit != ~^shreg) begin
                        parity_err_nxt = 1'b1;
                    end else if (data_vld && !data_rdy) begin
                        overrun_err_nxt = 1'b1;
                    end else begin
                        data_nxt     = shreg;
                        data_vld_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                br_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomized bench for uart_rx_byte; expectations come from a
// frame-level model (byte, parity, stop -> outcome) kept in the bench.
module tb_uart_rx_byte;

    localparam int BR = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          data_rdy = 1'b1;
    logic [DW-1:0] data;
    logic          data_vld, parity_err, frame_err, overrun_err;

    uart_rx_byte #(.BR(BR), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_rdy    (data_rdy),
        .data        (data),
        .data_vld    (data_vld),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed events
    int         n_par = 0, n_frm = 0, n_ovr = 0;
    logic [7:0] acc_q[$];
    bit         x_seen = 1'b0;

    // model expectations
    int         exp_par = 0, exp_frm = 0, exp_ovr = 0;
    logic [7:0] exp_q[$];
    bit         m_vld = 1'b0;
    logic [7:0] m_data = 8'h00;

    // Inputs only change 2 time units after a rising edge, so at the falling
    // edge they equal what the DUT sees at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if ($isunknown({data, data_vld, parity_err, frame_err, overrun_err})) x_seen = 1'b1;
            if (parity_err)  n_par++;
            if (frame_err)   n_frm++;
            if (overrun_err) n_ovr++;
            if (data_vld && data_rdy) acc_q.push_back(data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit good_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit p, input bit stop);
        if (!stop) exp_frm++;
        else if ((($countones(b) + int'(p)) % 2) != 1) exp_par++;
        else if (m_vld && !data_rdy) exp_ovr++;
        else begin
            m_vld  = 1'b1;
            m_data = b;
            if (data_rdy) begin
                exp_q.push_back(b);
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit p, input bit stop);
        model_frame(b, p, stop);
        rx = 1'b0;
        tick(BR);
        for (int i = 0; i < DW; i++) begin
            rx = b[i];
            tick(BR);
        end
        rx = p;
        tick(BR);
        rx = stop;
        tick(BR);
        rx = 1'b1;
    endtask

    task automatic check_all(input string tag);
        int n;
        check({tag, "_parity_cnt"},  n_par, exp_par);
        check({tag, "_frame_cnt"},   n_frm, exp_frm);
        check({tag, "_overrun_cnt"}, n_ovr, exp_ovr);
        check({tag, "_accept_cnt"},  acc_q.size(), exp_q.size());
        check({tag, "_data_vld"},    data_vld, m_vld);
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_accept_byte"}, acc_q[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] b;
        bit         p, stop;
        int         k;

        tick(3);
        check("reset_data",     data, 0);
        check("reset_data_vld", data_vld, 0);
        check("reset_flags",    {parity_err, frame_err, overrun_err}, 0);
        rst = 1'b0;
        tick(2 * BR);

        // 1: good byte
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(2 * BR);
        check_all("t1");
        check("t1_data", data, 8'hA5);

        // 2: wrong parity
        send_frame(8'h00, 1'b0, 1'b1);
        tick(2 * BR);
        check_all("t2");

        // 3: stop low, then recovery
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        tick(2 * BR);
        send_frame(8'h3C, good_par(8'h3C), 1'b1);
        tick(2 * BR);
        check_all("t3");
        check("t3_data", data, 8'h3C);

        // 4: short low glitch
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * BR);
        check_all("t4");

        // 5: overrun with downstream stalled
        data_rdy = 1'b0;
        send_frame(8'h11, good_par(8'h11), 1'b1);
        send_frame(8'h22, good_par(8'h22), 1'b1);
        tick(2 * BR);
        check_all("t5_hold");
        check("t5_data", data, 8'h11);
        data_rdy = 1'b1;
        if (m_vld) begin
            exp_q.push_back(m_data);
            m_vld = 1'b0;
        end
        tick(3);
        check_all("t5_accept");

        // 6: reset in the middle of a frame
        b  = 8'h5A;
        rx = 1'b0;
        tick(BR);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            tick(BR);
        end
        rst = 1'b1;
        tick(2);
        check("t6_rst_data_vld", data_vld, 0);
        check("t6_rst_data", data, 0);
        rx = 1'b1;
        tick(2);
        rst   = 1'b0;
        m_vld = 1'b0;
        tick(2 * BR);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        tick(2 * BR);
        check_all("t6");
        check("t6_data", data, 8'h5A);

        // randomized frames: good, bad parity, bad stop
        for (int f = 0; f < 24; f++) begin
            b    = 8'($urandom);
            k    = int'($urandom_range(0, 3));
            p    = good_par(b);
            stop = 1'b1;
            if (k == 2) p = ~p;
            if (k == 3) begin
                stop = 1'b0;
                p    = 1'($urandom);
            end
            send_frame(b, p, stop);
            tick(BR * int'($urandom_range(1, 2)));
        end
        tick(2 * BR);
        check_all("rand");
        check("no_x", x_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
